// File: rtl/demux4x32_buf_pkg.sv
// -----------------------------------------------------------------------------
// demux4x32_buf_pkg
// Shared constants for the 1:4 buffered word demultiplexer:
//   WIDTH_DEF  default data word width
//   NCH        number of destination channels
//   chan_sel_e select encodings CH0..CH3 for the 2-bit destination select
// -----------------------------------------------------------------------------
package demux4x32_buf_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NCH       = 4;

    typedef enum logic [1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2,
        CH3 = 2'd3
    } chan_sel_e;

endpackage : demux4x32_buf_pkg

// File: rtl/demux4x32_buf_chan_fifo.sv
// -----------------------------------------------------------------------------
// demux_chan_fifo
// One destination channel: a DEPTH-entry FIFO with a valid/ready style
// head presentation.
// Ports:
//   Clk   in   rising-edge clock
//   Rst   in   synchronous active-high reset, empties the FIFO
//   push  in   write din this edge (ignored while full)
//   din   in   word to write
//   full  out  count == DEPTH
//   pop   in   consumer takes dout this edge (ignored while empty)
//   dout  out  head word, forced to 0 while empty
//   valid out  FIFO holds at least one word
// -----------------------------------------------------------------------------
module demux_chan_fifo
    import demux4x32_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    wptr_d;
    logic [PW-1:0]    rptr_q;
    logic [PW-1:0]    rptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign valid     = (count_q != {CW{1'b0}});
    // Guarding here keeps the FIFO safe even if a caller ignores full/valid.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && valid;
    // Empty channels present zero so stale storage never leaks out.
    assign dout      = valid ? mem_q[rptr_q] : {WIDTH{1'b0}};

    // Next-state for pointers and occupancy; DEPTH is a power of two so
    // pointers wrap by natural overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok_s) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_ok_s) begin
            rptr_d = rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset wins over any push or pop.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because dout is gated by valid.
    always_ff @(posedge Clk) begin
        if (!Rst && push_ok_s) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule : demux_chan_fifo

// File: rtl/demux4x32_buf.sv
// -----------------------------------------------------------------------------
// demux4x32_buf
// Steers one input word stream to one of four buffered destination channels.
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   D, S, DValid    input word, destination select, word valid
//   DReady          channel S can accept a word (combinational on S)
//   Y0..Y3, V0..V3  head word / head valid of each channel
//   R0..R3          consumer i takes Yi this cycle
// -----------------------------------------------------------------------------
module demux4x32_buf
    import demux4x32_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       S,
    input  logic             DValid,
    output logic             DReady,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic             V0,
    output logic             V1,
    output logic             V2,
    output logic             V3,
    input  logic             R0,
    input  logic             R1,
    input  logic             R2,
    input  logic             R3
);

    logic [NCH-1:0]   full_s;
    logic [NCH-1:0]   push_s;
    logic [NCH-1:0]   pop_s;
    logic [NCH-1:0]   valid_s;
    logic [WIDTH-1:0] dout_s [NCH];

    assign pop_s = {R3, R2, R1, R0};

    // Readiness depends only on the channel currently addressed by S.
    always_comb begin
        DReady = 1'b0;
        case (chan_sel_e'(S))
            CH0:     DReady = !full_s[0];
            CH1:     DReady = !full_s[1];
            CH2:     DReady = !full_s[2];
            CH3:     DReady = !full_s[3];
            default: DReady = 1'b0;
        endcase
    end

    // One-hot push decode of an accepted word.
    always_comb begin
        push_s = {NCH{1'b0}};
        if (DValid && DReady) begin
            push_s = NCH'(1) << S;
        end else begin
            push_s = {NCH{1'b0}};
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .Clk   (Clk),
            .Rst   (Rst),
            .push  (push_s[i]),
            .din   (D),
            .full  (full_s[i]),
            .pop   (pop_s[i]),
            .dout  (dout_s[i]),
            .valid (valid_s[i])
        );
    end

    assign Y0 = dout_s[0];
    assign Y1 = dout_s[1];
    assign Y2 = dout_s[2];
    assign Y3 = dout_s[3];
    assign V0 = valid_s[0];
    assign V1 = valid_s[1];
    assign V2 = valid_s[2];
    assign V3 = valid_s[3];

endmodule : demux4x32_buf

// File: tb/tb_demux4x32_buf.sv
module tb_demux4x32_buf;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] D;
    logic [1:0]  S;
    logic        DValid;
    logic        DReady;
    logic [31:0] Y0, Y1, Y2, Y3;
    logic        V0, V1, V2, V3;
    logic        R0, R1, R2, R3;

    int n_tests = 0;
    int n_fail  = 0;

    demux4x32_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .Clk(Clk), .Rst(Rst), .D(D), .S(S), .DValid(DValid), .DReady(DReady),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
        .V0(V0), .V1(V1), .V2(V2), .V3(V3),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3)
    );

    always #5 Clk = ~Clk;

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        int exp_out;
        int nxt_in;
        logic acc;
        logic popping;

        Rst = 1'b1; DValid = 1'b1; S = 2'd0; D = 32'hCAFEF00D;
        R0 = 1'b0; R1 = 1'b0; R2 = 1'b0; R3 = 1'b0;

        // Reset held two cycles with DValid high
        tick(); tick();
        chk("rst_v", {28'd0, V3, V2, V1, V0}, 32'd0);
        chk("rst_y0", Y0, 32'd0);
        chk("rst_y3", Y3, 32'd0);
        chk("rst_rdy", {31'd0, DReady}, 32'd1);
        Rst = 1'b0; DValid = 1'b0;
        tick();
        chk("rst_nostore", {28'd0, V3, V2, V1, V0}, 32'd0);

        // Routing
        DValid = 1'b1; S = 2'd0; D = 32'h12345678; tick();
        chk("rt_y0", Y0, 32'h12345678);
        chk("rt_v0", {31'd0, V0}, 32'd1);
        chk("rt_y1_pre", Y1, 32'd0);
        S = 2'd1; D = 32'h87654321; tick();
        chk("rt_y1", Y1, 32'h87654321);
        chk("rt_y2_pre", Y2, 32'd0);
        S = 2'd2; D = 32'hABCDEF01; tick();
        chk("rt_y2", Y2, 32'hABCDEF01);
        chk("rt_y3_pre", Y3, 32'd0);
        S = 2'd3; D = 32'h10101010; tick();
        chk("rt_y3", Y3, 32'h10101010);
        chk("rt_v_all", {28'd0, V3, V2, V1, V0}, 32'hF);
        chk("rt_y0_keep", Y0, 32'h12345678);
        DValid = 1'b0;

        // Drain all four channels together
        R0 = 1'b1; R1 = 1'b1; R2 = 1'b1; R3 = 1'b1; tick();
        R0 = 1'b0; R1 = 1'b0; R2 = 1'b0; R3 = 1'b0;
        chk("drain_v", {28'd0, V3, V2, V1, V0}, 32'd0);

        // Full / backpressure on channel 0
        DValid = 1'b1; S = 2'd0; D = 32'hFFFFFFFF; tick();
        D = 32'h00000000; tick();
        DValid = 1'b0; #1;
        chk("full_rdy_s0", {31'd0, DReady}, 32'd0);
        S = 2'd2; #1;
        chk("full_rdy_s2", {31'd0, DReady}, 32'd1);
        DValid = 1'b1; S = 2'd0; D = 32'h55555555; tick();
        chk("full_hold_y0", Y0, 32'hFFFFFFFF);
        chk("full_hold_rdy", {31'd0, DReady}, 32'd0);
        R0 = 1'b1; #1;
        chk("full_no_pass", {31'd0, DReady}, 32'd0);
        tick();
        R0 = 1'b0; #1;
        chk("full_pop_y0", Y0, 32'h00000000);
        chk("full_pop_v0", {31'd0, V0}, 32'd1);
        chk("full_pop_rdy", {31'd0, DReady}, 32'd1);
        tick();
        DValid = 1'b0;
        chk("full_acc_y0", Y0, 32'h00000000);
        R0 = 1'b1; tick();
        chk("full_third", Y0, 32'h55555555);
        tick();
        chk("full_empty", {31'd0, V0}, 32'd0);
        R0 = 1'b0;

        // Simultaneous push and pop on channel 3
        DValid = 1'b1; S = 2'd3; D = 32'hAAAAAAAA; tick();
        chk("sim_y3_a", Y3, 32'hAAAAAAAA);
        D = 32'h55555555; R3 = 1'b1; tick();
        DValid = 1'b0; R3 = 1'b0; #1;
        chk("sim_y3_b", Y3, 32'h55555555);
        chk("sim_v3", {31'd0, V3}, 32'd1);
        chk("sim_rdy", {31'd0, DReady}, 32'd1);
        DValid = 1'b1; D = 32'h00000001; tick();
        DValid = 1'b0; #1;
        chk("sim_cnt_full", {31'd0, DReady}, 32'd0);
        R3 = 1'b1; tick();
        chk("sim_next", Y3, 32'h00000001);
        tick();
        chk("sim_empty", {31'd0, V3}, 32'd0);
        R3 = 1'b0;

        // Wrap-around stream through channel 1 with R1 toggling
        exp_out = 1; nxt_in = 1;
        for (int cyc = 0; cyc < 40 && exp_out <= 8; cyc++) begin
            S = 2'd1;
            DValid = (nxt_in <= 8);
            D = nxt_in;
            R1 = cyc[0];
            #1;
            acc = DValid && DReady;
            popping = V1 && R1;
            if (popping) begin
                chk("wrap_order", Y1, exp_out);
                exp_out++;
            end
            if (acc) nxt_in++;
            tick();
        end
        DValid = 1'b0; R1 = 1'b0;
        chk("wrap_count", exp_out, 9);
        #1;
        chk("wrap_empty", {31'd0, V1}, 32'd0);

        // Reset mid-operation
        DValid = 1'b1; S = 2'd0; D = 32'h11111111; tick();
        D = 32'h22222222; tick();
        S = 2'd2; D = 32'h33333333; tick();
        D = 32'h44444444; tick();
        DValid = 1'b0;
        chk("mid_pre_v", {28'd0, V3, V2, V1, V0}, 32'h5);
        Rst = 1'b1; tick();
        Rst = 1'b0; S = 2'd0; #1;
        chk("mid_v", {28'd0, V3, V2, V1, V0}, 32'd0);
        chk("mid_y0", Y0, 32'd0);
        chk("mid_y2", Y2, 32'd0);
        chk("mid_rdy", {31'd0, DReady}, 32'd1);
        DValid = 1'b1; S = 2'd2; D = 32'hDEADBEEF; tick();
        DValid = 1'b0;
        chk("mid_y2_new", Y2, 32'hDEADBEEF);
        chk("mid_v_alone", {28'd0, V3, V2, V1, V0}, 32'h4);
        R2 = 1'b1; tick();
        R2 = 1'b0;
        chk("mid_single", {31'd0, V2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_demux4x32_buf

// File: doc/demux4x32_buf.md
Name: demux4x32_buf

Overview:
- Inverse of the datapath 4:1 word selector: steers one 32-bit input stream to one of four 32-bit destination channels, chosen per word by a 2-bit select.
- Each channel has a small FIFO and a valid/ready handshake, so a stalled destination does not lose data.
- Sits between a single producer (e.g. write-back or bus response path) and four consumers in the CPU datapath.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 2, entries per channel FIFO; must be a power of two, at least 2.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous active-high reset.
- D  in  WIDTH  input word.
- S  in  2  destination select for D (0..3).
- DValid  in  1  D/S valid this cycle.
- DReady  out  1  block can accept the word addressed by S.
- Y0..Y3  out  WIDTH each  head word of channel i.
- V0..V3  out  1 each  channel i has a word (Yi valid).
- R0..R3  in  1 each  consumer i takes Yi this cycle.

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high; it is sampled on the Clk rising edge.
- Reset: all read/write pointers and counts go to 0. V0..V3=0 and Y0..Y3=0 from the first edge with Rst=1. DReady=1 after reset. Reset mid-operation discards all buffered words.
- DReady is combinational: DReady = !full[S]. It depends only on channel S; the state of the other channels is irrelevant.
- Push: on an edge with DValid && DReady, write D into FIFO[S] and increment its count. With DValid=0, S and D are don't-care.
- Pop: on an edge with Vi && Ri, advance channel i's read pointer and decrement its count. Ri while Vi=0 is ignored.
- Latency: a word pushed at edge k appears on Ys with Vs=1 in the cycle after edge k (1-cycle latency). There is no combinational D->Y path.
- Vi = (count_i != 0).
- Yi = head entry when Vi=1, else 0. Yi is never X after reset.
- Simultaneous push and pop on the same channel (not full, not empty): both occur and the count is unchanged. Order is preserved.
- Full channel: DReady=0 while S selects it, even if Ri=1 in the same cycle (no pass-through when full). The producer holds D/S until accepted.
- Pops on different channels in the same cycle are independent. Any subset of R0..R3 may be asserted.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1, and count never exceeds DEPTH.
- Per-channel ordering is strict FIFO. No ordering is guaranteed across channels.
- Rst has priority over push and pop on the same edge.

Decomposition:
- Shared package/header: WIDTH default, channel count constant NCH=4, select encodings CH0..CH3 = 2'd0..2'd3.
- One natural sub-module, demux_chan_fifo (params WIDTH, DEPTH):
  - Ports: Clk, Rst, push, din, full, pop, dout, valid.
  - Instantiated four times.
  - The top level holds only select decode, push_i = DValid && DReady && (S==i), and the DReady mux.

Test Plan:
- Reset: assert Rst 2 cycles with DValid=1 -> V0..V3=0, Y0..Y3=0, DReady=1, and no word stored after Rst drops.
- Routing: push 32'h12345678/S=0, 32'h87654321/S=1, 32'hABCDEF01/S=2, 32'h10101010/S=3 on consecutive cycles with R=0 -> each Yi shows its word one cycle after its push, Vi=1, other Y stay 0 until written.
- Full/backpressure: with DEPTH=2 and R0=0, push 32'hFFFFFFFF then 32'h00000000 to S=0 -> DReady=0 for S=0, while DReady=1 when S=2.
  - A third word 32'h55555555 is held, not accepted, until R0=1.
  - After the pop, Y0=32'h00000000 and 32'h55555555 is accepted on the next edge.
- Simultaneous push/pop: channel 3 holding 32'hAAAAAAAA, count=1; push 32'h55555555/S=3 with R3=1 -> count stays 1, Y3=32'h55555555 next cycle, no loss or duplication.
- Wrap-around: stream 8 words 32'h00000001..32'h00000008 through channel 1 with R1 toggling every cycle -> Y1 emits 1..8 in order; pointers wrap with no skipped or repeated word.
- Reset mid-operation: fill channels 0 and 2, assert Rst for 1 cycle -> V0=V2=0, Y0=Y2=0 next cycle, DReady=1. A subsequent push of 32'hDEADBEEF/S=2 appears alone on Y2.
